// File: rtl/des_key_scheduler_pkg.sv
// Shared DES constants: datapath widths, per-round rotate tables, PC-2 table,
// FSM encoding and the 28-bit half rotation helpers.
package des_key_scheduler_pkg;

  localparam int key_w  = 56;
  localparam int sub_w  = 48;
  localparam int half_w = 28;

  localparam int perm_pc2 = 5;

  typedef enum logic [0:0] {
    st_idle = 1'b0,
    st_run  = 1'b1
  } state_t;

  // Entry i holds the rotation applied when moving into round i+1.
  localparam logic [1:0] enc_rot [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };
  localparam logic [1:0] dec_rot [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // 1-based DES bit numbers, DES bit 1 being the MSB of the 56-bit input.
  localparam int pc2_tab [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [half_w-1:0] rot_half(input logic [half_w-1:0] h,
                                                 input logic [1:0] amt,
                                                 input logic right);
    logic [half_w-1:0] r;
    case ({right, amt})
      3'b0_01: r = {h[half_w-2:0], h[half_w-1]};
      3'b0_10: r = {h[half_w-3:0], h[half_w-1:half_w-2]};
      3'b1_01: r = {h[0], h[half_w-1:1]};
      3'b1_10: r = {h[1:0], h[half_w-1:2]};
      default: r = h;
    endcase
    return r;
  endfunction

  function automatic logic [key_w-1:0] rot_cd(input logic [key_w-1:0] cd,
                                              input logic [1:0] amt,
                                              input logic right);
    return {rot_half(cd[key_w-1:half_w], amt, right),
            rot_half(cd[half_w-1:0], amt, right)};
  endfunction

endpackage

// File: rtl/des_key_scheduler_if.sv
// Request/subkey handshake between the cipher control and the key scheduler.
interface des_key_scheduler_if;
  import des_key_scheduler_pkg::*;

  logic              start;
  logic              decrypt;
  logic [key_w-1:0]  key_in;
  logic              subkey_ready;
  logic              ready;
  logic              subkey_valid;
  logic [sub_w-1:0]  subkey;
  logic [4:0]        round;
  logic              done;

  modport master (
    output start, decrypt, key_in, subkey_ready,
    input  ready, subkey_valid, subkey, round, done
  );

  modport slave (
    input  start, decrypt, key_in, subkey_ready,
    output ready, subkey_valid, subkey, round, done
  );
endinterface

// File: rtl/p_function.sv
// Fixed bit permutation selected by perm_id; only PC-2 (56 -> 48) is defined.
module p_function
  import des_key_scheduler_pkg::*;
#(
  parameter int in_w    = 56,
  parameter int out_w   = 48,
  parameter int perm_id = 5
) (
  input  logic [in_w-1:0]  din,
  output logic [out_w-1:0] dout
);

  logic unused_s;
  assign unused_s = ^din;

  generate
    if (perm_id == perm_pc2 && in_w == key_w && out_w == sub_w) begin : g_pc2
      for (genvar i = 0; i < out_w; i++) begin : g_bit
        assign dout[out_w-1-i] = din[in_w-pc2_tab[i]];
      end
    end else begin : g_none
      assign dout = '0;
    end
  endgenerate

endmodule

// File: rtl/des_key_scheduler.sv
// Iterative DES subkey generator: one subkey per accepted handshake, K1..K16
// for encryption or K16..K1 for decryption.
module des_key_scheduler
  import des_key_scheduler_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  des_key_scheduler_if.slave bus
);

  state_t            state_r;
  logic [key_w-1:0]  cd_r;
  logic [4:0]        round_r;
  logic              dec_r;
  logic              done_r;
  logic [sub_w-1:0]  pc2_s;
  logic [1:0]        step_amt_s;

  p_function #(key_w, sub_w, perm_pc2) u_pc2 (
    .din  (cd_r),
    .dout (pc2_s)
  );

  // round_r is 1..15 whenever a step is taken, so its low nibble indexes the next round.
  assign step_amt_s = dec_r ? dec_rot[round_r[3:0]] : enc_rot[round_r[3:0]];

  // Round sequencing FSM: owns cd, round, the latched direction and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= st_idle;
      cd_r    <= '0;
      round_r <= 5'd0;
      dec_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        st_idle: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state_r <= st_run;
            dec_r   <= bus.decrypt;
            round_r <= 5'd1;
            cd_r    <= rot_cd(bus.key_in,
                              bus.decrypt ? dec_rot[0] : enc_rot[0],
                              bus.decrypt);
          end
        end
        st_run: begin
          done_r <= 1'b0;
          if (bus.subkey_ready) begin
            if (round_r == 5'd16) begin
              state_r <= st_idle;
              round_r <= 5'd0;
              done_r  <= 1'b1;
            end else begin
              round_r <= round_r + 5'd1;
              cd_r    <= rot_cd(cd_r, step_amt_s, dec_r);
            end
          end
        end
        default: begin
          state_r <= st_idle;
          round_r <= 5'd0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready        = (state_r == st_idle);
  assign bus.subkey_valid = (state_r == st_run);
  assign bus.subkey       = (state_r == st_run) ? pc2_s : {sub_w{1'b0}};
  assign bus.round        = round_r;
  assign bus.done         = done_r;

endmodule

// File: tb/tb_des_key_scheduler.sv
// Directed and randomized checks of des_key_scheduler against a textbook
// DES key-schedule model (cumulative left shifts, order reversed for decrypt).
module tb_des_key_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  des_key_scheduler_if bus ();

  des_key_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  localparam int shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int pc2_ref [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  logic [47:0] exp_k [1:16];
  logic [47:0] obs_k [1:16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Standard schedule: Ki from C0/D0 shifted left by the cumulative shift count.
  task automatic model(input logic [55:0] key, input logic dec);
    logic [27:0] c;
    logic [27:0] d;
    logic [55:0] cd;
    logic [47:0] ks [1:16];
    c = key[55:28];
    d = key[27:0];
    for (int i = 1; i <= 16; i++) begin
      c = (c << shifts[i-1]) | (c >> (28 - shifts[i-1]));
      d = (d << shifts[i-1]) | (d >> (28 - shifts[i-1]));
      cd = {c, d};
      for (int b = 0; b < 48; b++) ks[i][47-b] = cd[56-pc2_ref[b]];
    end
    for (int r = 1; r <= 16; r++) exp_k[r] = dec ? ks[17-r] : ks[r];
  endtask

  task automatic run_sched(input logic [55:0] key, input logic dec, input int stall_r,
                           input bit rnd_stall, input bit mid_start, input bit abort7);
    int n;
    model(key, dec);
    chk("ready_at_start", 64'(bus.ready), 64'd1);
    bus.key_in       = key;
    bus.decrypt      = dec;
    bus.start        = 1'b1;
    bus.subkey_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int r = 1; r <= 16; r++) begin
      chk("valid", 64'(bus.subkey_valid), 64'd1);
      chk("round", 64'(bus.round), 64'(r));
      chk("subkey", 64'(bus.subkey), 64'(exp_k[r]));
      chk("no_early_done", 64'(bus.done), 64'd0);
      chk("busy_not_ready", 64'(bus.ready), 64'd0);
      obs_k[r] = bus.subkey;
      bus.key_in  = 56'({$urandom(), $urandom()});
      bus.decrypt = 1'($urandom_range(0, 1));
      if (mid_start && r == 5) bus.start = 1'b1;
      if (abort7 && r == 7) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", 64'(bus.ready), 64'd1);
        chk("abort_valid", 64'(bus.subkey_valid), 64'd0);
        chk("abort_subkey", 64'(bus.subkey), 64'd0);
        chk("abort_round", 64'(bus.round), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        return;
      end
      n = (r == stall_r) ? 5 : (rnd_stall ? int'($urandom_range(0, 3)) : 0);
      if (n > 0) begin
        bus.subkey_ready = 1'b0;
        repeat (n) begin
          @(negedge clk);
          chk("stall_valid", 64'(bus.subkey_valid), 64'd1);
          chk("stall_round", 64'(bus.round), 64'(r));
          chk("stall_subkey", 64'(bus.subkey), 64'(exp_k[r]));
        end
      end
      bus.subkey_ready = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("done_pulse", 64'(bus.done), 64'd1);
    chk("done_ready", 64'(bus.ready), 64'd1);
    chk("done_valid", 64'(bus.subkey_valid), 64'd0);
    chk("done_subkey", 64'(bus.subkey), 64'd0);
    chk("done_round", 64'(bus.round), 64'd0);
  endtask

  // One idle cycle after a schedule: done must have dropped, subkey_ready is don't-care.
  task automatic idle_chk();
    bus.subkey_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("done_once", 64'(bus.done), 64'd0);
    chk("idle_ready", 64'(bus.ready), 64'd1);
    chk("idle_valid", 64'(bus.subkey_valid), 64'd0);
    chk("idle_subkey", 64'(bus.subkey), 64'd0);
  endtask

  initial begin
    logic [55:0] tv_key;
    logic [47:0] k1_tv;
    logic [47:0] k2_tv;
    logic [47:0] k16_tv;
    bit chain;
    tv_key = 56'hF0CCAAF556678F;
    k1_tv  = 48'h1B02EFFC7072;
    k2_tv  = 48'h79AED9DBC9E5;
    k16_tv = 48'hCB3D8B0E17F5;

    rst              = 1'b1;
    bus.start        = 1'b1;
    bus.decrypt      = 1'b0;
    bus.key_in       = tv_key;
    bus.subkey_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_valid", 64'(bus.subkey_valid), 64'd0);
    chk("rst_subkey", 64'(bus.subkey), 64'd0);
    chk("rst_round", 64'(bus.round), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    idle_chk();

    run_sched(tv_key, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("tv_enc_k1", 64'(obs_k[1]), 64'(k1_tv));
    chk("tv_enc_k2", 64'(obs_k[2]), 64'(k2_tv));
    chk("tv_enc_k16", 64'(obs_k[16]), 64'(k16_tv));
    idle_chk();

    run_sched(tv_key, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk("tv_dec_k1", 64'(obs_k[1]), 64'(k16_tv));
    chk("tv_dec_k16", 64'(obs_k[16]), 64'(k1_tv));
    idle_chk();

    run_sched(tv_key, 1'b0, 9, 1'b0, 1'b0, 1'b0);
    idle_chk();

    run_sched(56'({$urandom(), $urandom()}), 1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle_chk();

    run_sched(tv_key, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    run_sched(56'({$urandom(), $urandom()}), 1'b1, 0, 1'b1, 1'b0, 1'b0);
    idle_chk();

    for (int t = 0; t < 10; t++) begin
      chain = 1'($urandom_range(0, 1));
      run_sched(56'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 16)), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      if (!chain) idle_chk();
    end
    idle_chk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
